// File: rtl/fact_requester.sv
// Request source and self-test engine for the factorial unit: sweeps n over
// N_FIRST..N_LAST, pulses inicio per value, captures salida on fin and counts mismatches.
//
// state    | meaning
// IDLE     | waiting for go; results of the last sweep held
// ISSUE    | inicio high for this single cycle, wait counter cleared
// WAIT_FIN | waiting for fin, counting cycles toward TIMEOUT
// CHECK    | compare captured result with the golden table
// WAIT_LOW | wait for fin to drop, then advance n or finish
// DONE     | one-cycle done pulse, then back to IDLE
module fact_requester #(
    parameter int N_FIRST = 0,
    parameter int N_LAST  = 7,
    parameter int TIMEOUT = 255,
    parameter int W       = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    output logic         inicio,
    output logic [2:0]   n,
    input  logic [W-1:0] salida,
    input  logic         fin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] last_result,
    output logic [3:0]   err_cnt,
    output logic         timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [2:0]    N_FIRST_L = 3'(N_FIRST);
    localparam logic [2:0]    N_LAST_L  = 3'(N_LAST);
    localparam logic [CW-1:0] TIMEOUT_L = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_FIN,
        CHECK,
        WAIT_LOW,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    function automatic logic [W-1:0] golden(input logic [2:0] k);
        case (k)
            3'd0:    return W'(1);
            3'd1:    return W'(1);
            3'd2:    return W'(2);
            3'd3:    return W'(6);
            3'd4:    return W'(24);
            3'd5:    return W'(120);
            3'd6:    return W'(720);
            default: return W'(5040);
        endcase
    endfunction

    function automatic logic [3:0] err_inc(input logic [3:0] cnt);
        return (cnt == 4'hF) ? cnt : cnt + 4'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            inicio      <= 1'b0;
            n           <= 3'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            last_result <= '0;
            err_cnt     <= 4'd0;
            timeout     <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        n       <= N_FIRST_L;
                        err_cnt <= 4'd0;
                        timeout <= 1'b0;
                        inicio  <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    inicio   <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT_FIN;
                end
                WAIT_FIN: begin
                    if (fin) begin
                        last_result <= salida;
                        state       <= CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                        // abort on the cycle the counter would reach TIMEOUT
                        if (wait_cnt + CW'(1) == TIMEOUT_L) begin
                            timeout <= 1'b1;
                            err_cnt <= err_inc(err_cnt);
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                CHECK: begin
                    if (last_result != golden(n))
                        err_cnt <= err_inc(err_cnt);
                    state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!fin) begin
                        if (n == N_LAST_L) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            n      <= n + 3'd1;
                            inicio <= 1'b1;
                            state  <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    inicio <= 1'b0;
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
